// File: rtl/force_sum_pkg.sv
// -----------------------------------------------------------------------------
// force_sum_pkg
// Shared types and sizing for the force summation scheduler: FSM state enum,
// force vector type, source FIFO entry and ID tag payloads, and the ID
// comparison helper used by the issue logic.
// -----------------------------------------------------------------------------
package force_sum_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned ID_WIDTH       = 12;
  localparam int unsigned SRC_FIFO_DEPTH = 4;
  localparam int unsigned SUM_LATENCY    = 6;
  localparam int unsigned CNT_WIDTH      = ID_WIDTH + 1;
  localparam int unsigned DRAIN_WIDTH    = $clog2(SUM_LATENCY + 1);

  // {z,y,x} FP32 force components
  typedef logic [3*DATA_WIDTH-1:0] force_vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // One buffered force sample from a source engine
  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    force_vec_t          frc;
  } src_entry_t;

  // One slot of the ID tag pipeline that shadows the summation unit
  typedef struct packed {
    logic                valid;
    logic [ID_WIDTH-1:0] id;
  } id_tag_t;

  // True when the participating head IDs disagree
  function automatic logic ids_differ(input logic [ID_WIDTH-1:0] lr_id,
                                      input logic [ID_WIDTH-1:0] sr_id,
                                      input logic [ID_WIDTH-1:0] bf_id,
                                      input logic                use_bf);
    return (lr_id != sr_id) || (use_bf && (lr_id != bf_id));
  endfunction

endpackage

// File: rtl/force_src_fifo.sv
// -----------------------------------------------------------------------------
// force_src_fifo
// Per-source circular buffer with registered full/valid flags. A push is
// accepted only when not full; a pop is accepted only when not empty. The head
// entry is read straight out of the storage registers, so a push is visible
// at the head on the following cycle.
//
// Ports
//   clk, rst   clock, synchronous active-high reset (flushes contents)
//   push_i     write request, ignored while full
//   data_i     entry to write
//   pop_i      read request, ignored while empty
//   data_o     head entry
//   valid_o    head entry is valid (FIFO not empty)
//   full_o     FIFO holds DEPTH entries
// -----------------------------------------------------------------------------
module force_src_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             full_q;
  logic             valid_q;
  logic             push_c;
  logic             pop_c;

  assign push_c = push_i && !full_q;
  assign pop_c  = pop_i && valid_q;

  // Occupancy is unchanged on simultaneous push and pop
  always_comb begin
    count_d = count_q;
    if (push_c && !pop_c) begin
      count_d = count_q + CW'(1);
    end else if (pop_c && !push_c) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointers, occupancy and flags; pointers wrap because DEPTH is a power of 2
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      valid_q <= (count_d != '0);
    end
  end

  // Storage needs no reset; valid_q gates every use of the head
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = valid_q;
  assign full_o  = full_q;

endmodule

// File: rtl/force_sum_scheduler.sv
// -----------------------------------------------------------------------------
// force_sum_scheduler
// Buffers long-range, short-range and bonded force streams, aligns them by
// arrival order, and issues one operand triple per cycle to the fixed-latency
// summation unit. A tag pipeline shadows the summation unit so the particle ID
// emerges alongside each sum. Tracks pass progress and flags ID misalignment
// and summation latency faults.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   start_i                   begins a pass (IDLE/DONE only)
//   num_particles_i, bf_en_i  pass size and bonded-path enable, sampled on start
//   {lr,sr,bf}_valid_i/_id_i/_force_i   source force streams
//   {lr,sr,bf}_ready_o        source FIFO not full
//   sum_valid_in_o            issue strobe to summation unit
//   sum_force_{lr,sr,bf}_o    aligned operands (bf is zero when disabled)
//   sum_valid_out_i           summation unit result valid
//   out_id_o, out_id_valid_o  ID matching the current summed force
//   busy_o, done_o            pass status
//   err_mismatch_o, err_latency_o   sticky faults, cleared by start or rst
//   issued_cnt_o              particles issued this pass
// -----------------------------------------------------------------------------
module force_sum_scheduler
  import force_sum_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = SRC_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] num_particles_i,
  input  logic                 bf_en_i,
  input  logic                 lr_valid_i,
  input  logic [ID_WIDTH-1:0]  lr_id_i,
  input  force_vec_t           lr_force_i,
  input  logic                 sr_valid_i,
  input  logic [ID_WIDTH-1:0]  sr_id_i,
  input  force_vec_t           sr_force_i,
  input  logic                 bf_valid_i,
  input  logic [ID_WIDTH-1:0]  bf_id_i,
  input  force_vec_t           bf_force_i,
  output logic                 lr_ready_o,
  output logic                 sr_ready_o,
  output logic                 bf_ready_o,
  output logic                 sum_valid_in_o,
  output force_vec_t           sum_force_lr_o,
  output force_vec_t           sum_force_sr_o,
  output force_vec_t           sum_force_bf_o,
  input  logic                 sum_valid_out_i,
  output logic [ID_WIDTH-1:0]  out_id_o,
  output logic                 out_id_valid_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_mismatch_o,
  output logic                 err_latency_o,
  output logic [CNT_WIDTH-1:0] issued_cnt_o
);

  localparam int unsigned ENTRY_WIDTH = $bits(src_entry_t);
  localparam int unsigned TAG_LAST    = SUM_LATENCY - 1;

  state_e                 state_q;
  logic [CNT_WIDTH-1:0]   num_q;
  logic                   bf_en_q;
  logic [CNT_WIDTH-1:0]   issued_cnt_q;
  logic [DRAIN_WIDTH-1:0] drain_cnt_q;
  logic                   sum_valid_in_q;
  force_vec_t             op_lr_q;
  force_vec_t             op_sr_q;
  force_vec_t             op_bf_q;
  logic [ID_WIDTH-1:0]    issue_id_q;
  id_tag_t                tag_q [SUM_LATENCY];
  logic                   busy_q;
  logic                   done_q;
  logic                   err_mismatch_q;
  logic                   err_latency_q;

  src_entry_t lr_head;
  src_entry_t sr_head;
  src_entry_t bf_head;
  logic       lr_head_vld;
  logic       sr_head_vld;
  logic       bf_head_vld;
  logic       lr_full;
  logic       sr_full;
  logic       bf_full;

  logic       lr_push_c;
  logic       sr_push_c;
  logic       bf_push_c;
  logic       issue_c;
  logic       mismatch_c;

  // Bonded stream is dropped entirely while the bonded path is disabled
  assign lr_push_c = lr_valid_i && !lr_full;
  assign sr_push_c = sr_valid_i && !sr_full;
  assign bf_push_c = bf_valid_i && !bf_full && bf_en_q;

  force_src_fifo #(.WIDTH(ENTRY_WIDTH), .DEPTH(FIFO_DEPTH)) u_lr_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (lr_push_c),
    .data_i  ({lr_id_i, lr_force_i}),
    .pop_i   (issue_c),
    .data_o  (lr_head),
    .valid_o (lr_head_vld),
    .full_o  (lr_full)
  );

  force_src_fifo #(.WIDTH(ENTRY_WIDTH), .DEPTH(FIFO_DEPTH)) u_sr_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (sr_push_c),
    .data_i  ({sr_id_i, sr_force_i}),
    .pop_i   (issue_c),
    .data_o  (sr_head),
    .valid_o (sr_head_vld),
    .full_o  (sr_full)
  );

  force_src_fifo #(.WIDTH(ENTRY_WIDTH), .DEPTH(FIFO_DEPTH)) u_bf_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bf_push_c),
    .data_i  ({bf_id_i, bf_force_i}),
    .pop_i   (issue_c && bf_en_q),
    .data_o  (bf_head),
    .valid_o (bf_head_vld),
    .full_o  (bf_full)
  );

  // Issue when every participating head is present and the pass is not complete
  assign issue_c = (state_q == RUN) && (issued_cnt_q != num_q) &&
                   lr_head_vld && sr_head_vld && (!bf_en_q || bf_head_vld);

  assign mismatch_c = ids_differ(lr_head.id, sr_head.id, bf_head.id, bf_en_q);

  // Pass FSM, operand registers, ID tag pipeline and fault checks
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      num_q          <= '0;
      bf_en_q        <= 1'b0;
      issued_cnt_q   <= '0;
      drain_cnt_q    <= '0;
      sum_valid_in_q <= 1'b0;
      op_lr_q        <= '0;
      op_sr_q        <= '0;
      op_bf_q        <= '0;
      issue_id_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_mismatch_q <= 1'b0;
      err_latency_q  <= 1'b0;
      for (int unsigned i = 0; i < SUM_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      sum_valid_in_q <= issue_c;

      // Misaligned heads still issue under the lr ID; no resync is attempted
      if (issue_c) begin
        op_lr_q      <= lr_head.frc;
        op_sr_q      <= sr_head.frc;
        op_bf_q      <= bf_en_q ? bf_head.frc : '0;
        issue_id_q   <= lr_head.id;
        issued_cnt_q <= issued_cnt_q + CNT_WIDTH'(1);
        if (mismatch_c) begin
          err_mismatch_q <= 1'b1;
        end
      end

      // Fed from the registered strobe so the tail lines up with sum_valid_out
      tag_q[0] <= {sum_valid_in_q, issue_id_q};
      for (int unsigned i = 1; i < SUM_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end

      if (sum_valid_out_i != tag_q[TAG_LAST].valid) begin
        err_latency_q <= 1'b1;
      end

      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            num_q          <= num_particles_i;
            bf_en_q        <= bf_en_i;
            issued_cnt_q   <= '0;
            err_mismatch_q <= 1'b0;
            err_latency_q  <= 1'b0;
            if (!bf_en_i) begin
              op_bf_q <= '0;
            end
            if (num_particles_i == '0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        RUN: begin
          // The last strobe is already out, so drain counting starts at 1
          if (issued_cnt_q == num_q) begin
            state_q     <= DRAIN;
            drain_cnt_q <= DRAIN_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt_q == DRAIN_WIDTH'(SUM_LATENCY)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + DRAIN_WIDTH'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign lr_ready_o     = !lr_full;
  assign sr_ready_o     = !sr_full;
  assign bf_ready_o     = !bf_full;
  assign sum_valid_in_o = sum_valid_in_q;
  assign sum_force_lr_o = op_lr_q;
  assign sum_force_sr_o = op_sr_q;
  assign sum_force_bf_o = op_bf_q;
  assign out_id_o       = tag_q[TAG_LAST].id;
  assign out_id_valid_o = tag_q[TAG_LAST].valid;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_mismatch_o = err_mismatch_q;
  assign err_latency_o  = err_latency_q;
  assign issued_cnt_o   = issued_cnt_q;

endmodule

// File: tb/tb_force_sum_scheduler.sv
// -----------------------------------------------------------------------------
// tb_force_sum_scheduler
// Directed bench for force_sum_scheduler with a stub summation unit whose
// latency can be shortened to provoke the latency fault.
// -----------------------------------------------------------------------------
module tb_force_sum_scheduler;
  import force_sum_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start_i = 1'b0;
  logic [CNT_WIDTH-1:0] num_particles_i = '0;
  logic                 bf_en_i = 1'b0;
  logic                 lr_valid_i = 1'b0;
  logic [ID_WIDTH-1:0]  lr_id_i = '0;
  force_vec_t           lr_force_i = '0;
  logic                 sr_valid_i = 1'b0;
  logic [ID_WIDTH-1:0]  sr_id_i = '0;
  force_vec_t           sr_force_i = '0;
  logic                 bf_valid_i = 1'b0;
  logic [ID_WIDTH-1:0]  bf_id_i = '0;
  force_vec_t           bf_force_i = '0;
  logic                 lr_ready_o, sr_ready_o, bf_ready_o;
  logic                 sum_valid_in_o;
  force_vec_t           sum_force_lr_o, sum_force_sr_o, sum_force_bf_o;
  logic                 sum_valid_out_i;
  logic [ID_WIDTH-1:0]  out_id_o;
  logic                 out_id_valid_o;
  logic                 busy_o, done_o, err_mismatch_o, err_latency_o;
  logic [CNT_WIDTH-1:0] issued_cnt_o;

  int compared = 0;
  int failed   = 0;
  int cyc      = 0;
  int stub_lat = 6;
  logic [7:0] sv_pipe;

  // Event logs filled by the monitor
  int                  svi_cyc_q[$];
  force_vec_t          lr_q[$];
  force_vec_t          sr_q[$];
  force_vec_t          bf_q[$];
  int                  oiv_cyc_q[$];
  logic [ID_WIDTH-1:0] oid_q[$];

  force_sum_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start_i),
    .num_particles_i (num_particles_i),
    .bf_en_i         (bf_en_i),
    .lr_valid_i      (lr_valid_i),
    .lr_id_i         (lr_id_i),
    .lr_force_i      (lr_force_i),
    .sr_valid_i      (sr_valid_i),
    .sr_id_i         (sr_id_i),
    .sr_force_i      (sr_force_i),
    .bf_valid_i      (bf_valid_i),
    .bf_id_i         (bf_id_i),
    .bf_force_i      (bf_force_i),
    .lr_ready_o      (lr_ready_o),
    .sr_ready_o      (sr_ready_o),
    .bf_ready_o      (bf_ready_o),
    .sum_valid_in_o  (sum_valid_in_o),
    .sum_force_lr_o  (sum_force_lr_o),
    .sum_force_sr_o  (sum_force_sr_o),
    .sum_force_bf_o  (sum_force_bf_o),
    .sum_valid_out_i (sum_valid_out_i),
    .out_id_o        (out_id_o),
    .out_id_valid_o  (out_id_valid_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_mismatch_o  (err_mismatch_o),
    .err_latency_o   (err_latency_o),
    .issued_cnt_o    (issued_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stub summation unit: sum_valid_out follows sum_valid_in by stub_lat cycles
  always @(posedge clk) begin
    if (rst) sv_pipe <= '0;
    else     sv_pipe <= {sv_pipe[6:0], sum_valid_in_o};
  end
  assign sum_valid_out_i = sv_pipe[stub_lat-1];

  // Monitor: record issue strobes and tagged results
  always @(negedge clk) begin
    if (sum_valid_in_o === 1'b1) begin
      svi_cyc_q.push_back(cyc);
      lr_q.push_back(sum_force_lr_o);
      sr_q.push_back(sum_force_sr_o);
      bf_q.push_back(sum_force_bf_o);
    end
    if (out_id_valid_o === 1'b1) begin
      oiv_cyc_q.push_back(cyc);
      oid_q.push_back(out_id_o);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic force_vec_t mk(input int src, input int id);
    logic [31:0] b;
    b = 32'(src * 4096 + id * 16);
    return {b + 32'd2, b + 32'd1, b};
  endfunction

  task automatic clear_logs();
    svi_cyc_q.delete(); lr_q.delete(); sr_q.delete(); bf_q.delete();
    oiv_cyc_q.delete(); oid_q.delete();
  endtask

  task automatic drive(input logic lv, input logic sv, input logic bv,
                       input int lid, input int sid, input int bid);
    lr_valid_i = lv; lr_id_i = ID_WIDTH'(lid); lr_force_i = mk(0, lid);
    sr_valid_i = sv; sr_id_i = ID_WIDTH'(sid); sr_force_i = mk(1, sid);
    bf_valid_i = bv; bf_id_i = ID_WIDTH'(bid); bf_force_i = mk(2, bid);
  endtask

  task automatic start_pass(input int n, input logic bfe);
    start_i = 1'b1; num_particles_i = CNT_WIDTH'(n); bf_en_i = bfe;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++; if (lr_ready_o !== 1'b1) begin failed++; $display("FAIL reset_lr_ready: got %b required 1", lr_ready_o); end
    compared++; if (sr_ready_o !== 1'b1) begin failed++; $display("FAIL reset_sr_ready: got %b required 1", sr_ready_o); end
    compared++; if (bf_ready_o !== 1'b1) begin failed++; $display("FAIL reset_bf_ready: got %b required 1", bf_ready_o); end
    compared++; if (sum_valid_in_o !== 1'b0) begin failed++; $display("FAIL reset_svi: got %b required 0", sum_valid_in_o); end
    compared++; if ({sum_force_lr_o, sum_force_sr_o, sum_force_bf_o} !== '0) begin failed++; $display("FAIL reset_operands: got %h required 0", {sum_force_lr_o, sum_force_sr_o, sum_force_bf_o}); end
    compared++; if ({out_id_valid_o, out_id_o} !== '0) begin failed++; $display("FAIL reset_out_id: got %h required 0", {out_id_valid_o, out_id_o}); end
    compared++; if ({busy_o, done_o} !== 2'b00) begin failed++; $display("FAIL reset_status: got %b required 00", {busy_o, done_o}); end
    compared++; if ({err_mismatch_o, err_latency_o} !== 2'b00) begin failed++; $display("FAIL reset_errs: got %b required 00", {err_mismatch_o, err_latency_o}); end
    compared++; if (issued_cnt_o !== '0) begin failed++; $display("FAIL reset_issued: got %0d required 0", issued_cnt_o); end
  endtask

  task automatic test_basic();
    int push_cyc;
    int done_cyc;
    int n;
    clear_logs();
    start_pass(3, 1'b1);
    compared++; if (busy_o !== 1'b1) begin failed++; $display("FAIL basic_busy: got %b required 1", busy_o); end
    push_cyc = cyc;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, i, i, i);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    n = 0;
    while (done_o !== 1'b1 && n < 80) begin @(negedge clk); n++; end
    done_cyc = cyc;
    compared++; if (done_o !== 1'b1) begin failed++; $display("FAIL basic_done_timeout: got %b required 1", done_o); end
    compared++; if (svi_cyc_q.size() != 3) begin failed++; $display("FAIL basic_svi_count: got %0d required 3", svi_cyc_q.size()); end
    for (int k = 0; k < 3 && k < svi_cyc_q.size(); k++) begin
      compared++;
      if (svi_cyc_q[k] != push_cyc + 2 + k) begin failed++; $display("FAIL basic_svi_cycle%0d: got %0d required %0d", k, svi_cyc_q[k], push_cyc + 2 + k); end
      compared++;
      if ({lr_q[k], sr_q[k], bf_q[k]} !== {mk(0, k), mk(1, k), mk(2, k)}) begin failed++; $display("FAIL basic_operands%0d: got %h required %h", k, {lr_q[k], sr_q[k], bf_q[k]}, {mk(0, k), mk(1, k), mk(2, k)}); end
    end
    compared++; if (oid_q.size() != 3) begin failed++; $display("FAIL basic_oiv_count: got %0d required 3", oid_q.size()); end
    for (int k = 0; k < 3 && k < oid_q.size() && k < svi_cyc_q.size(); k++) begin
      compared++;
      if (oid_q[k] !== ID_WIDTH'(k)) begin failed++; $display("FAIL basic_out_id%0d: got %0d required %0d", k, oid_q[k], k); end
      compared++;
      if (oiv_cyc_q[k] != svi_cyc_q[k] + 6) begin failed++; $display("FAIL basic_oiv_latency%0d: got %0d required %0d", k, oiv_cyc_q[k], svi_cyc_q[k] + 6); end
    end
    compared++; if (done_cyc != push_cyc + 4 + 7) begin failed++; $display("FAIL basic_done_cycle: got %0d required %0d", done_cyc, push_cyc + 11); end
    compared++; if (issued_cnt_o !== CNT_WIDTH'(3)) begin failed++; $display("FAIL basic_issued: got %0d required 3", issued_cnt_o); end
    compared++; if ({busy_o, err_mismatch_o, err_latency_o} !== 3'b000) begin failed++; $display("FAIL basic_end_flags: got %b required 000", {busy_o, err_mismatch_o, err_latency_o}); end
  endtask

  task automatic test_bf_off();
    force_vec_t zero_f;
    int n;
    zero_f = '0;
    clear_logs();
    start_pass(2, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 5, 5, 99);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 6, 6, 99);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    n = 0;
    while (done_o !== 1'b1 && n < 80) begin @(negedge clk); n++; end
    compared++; if (done_o !== 1'b1) begin failed++; $display("FAIL bfoff_done_timeout: got %b required 1", done_o); end
    compared++; if (svi_cyc_q.size() != 2) begin failed++; $display("FAIL bfoff_svi_count: got %0d required 2", svi_cyc_q.size()); end
    for (int k = 0; k < 2 && k < svi_cyc_q.size(); k++) begin
      compared++;
      if ({lr_q[k], sr_q[k], bf_q[k]} !== {mk(0, 5 + k), mk(1, 5 + k), zero_f}) begin failed++; $display("FAIL bfoff_operands%0d: got %h required %h", k, {lr_q[k], sr_q[k], bf_q[k]}, {mk(0, 5 + k), mk(1, 5 + k), zero_f}); end
    end
    for (int k = 0; k < 2 && k < oid_q.size(); k++) begin
      compared++;
      if (oid_q[k] !== ID_WIDTH'(5 + k)) begin failed++; $display("FAIL bfoff_out_id%0d: got %0d required %0d", k, oid_q[k], 5 + k); end
    end
    compared++; if (issued_cnt_o !== CNT_WIDTH'(2)) begin failed++; $display("FAIL bfoff_issued: got %0d required 2", issued_cnt_o); end
    compared++; if (err_mismatch_o !== 1'b0) begin failed++; $display("FAIL bfoff_mismatch: got %b required 0", err_mismatch_o); end
  endtask

  task automatic test_skew();
    int sr_first;
    int n;
    clear_logs();
    start_pass(4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, i, 0, 0);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    compared++; if (lr_ready_o !== 1'b0) begin failed++; $display("FAIL skew_lr_ready_full: got %b required 0", lr_ready_o); end
    compared++; if (sr_ready_o !== 1'b1) begin failed++; $display("FAIL skew_sr_ready: got %b required 1", sr_ready_o); end
    @(negedge clk);
    compared++; if (svi_cyc_q.size() != 0) begin failed++; $display("FAIL skew_early_issue: got %0d required 0", svi_cyc_q.size()); end
    sr_first = cyc;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 0, i, 0);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    n = 0;
    while (done_o !== 1'b1 && n < 80) begin @(negedge clk); n++; end
    compared++; if (done_o !== 1'b1) begin failed++; $display("FAIL skew_done_timeout: got %b required 1", done_o); end
    compared++; if (svi_cyc_q.size() != 4) begin failed++; $display("FAIL skew_svi_count: got %0d required 4", svi_cyc_q.size()); end
    for (int k = 0; k < 4 && k < svi_cyc_q.size(); k++) begin
      compared++;
      if (svi_cyc_q[k] != sr_first + 2 + k) begin failed++; $display("FAIL skew_svi_cycle%0d: got %0d required %0d", k, svi_cyc_q[k], sr_first + 2 + k); end
      compared++;
      if ({lr_q[k], sr_q[k]} !== {mk(0, k), mk(1, k)}) begin failed++; $display("FAIL skew_operands%0d: got %h required %h", k, {lr_q[k], sr_q[k]}, {mk(0, k), mk(1, k)}); end
    end
    compared++; if (lr_ready_o !== 1'b1) begin failed++; $display("FAIL skew_lr_ready_after: got %b required 1", lr_ready_o); end
    compared++; if (err_mismatch_o !== 1'b0) begin failed++; $display("FAIL skew_mismatch: got %b required 0", err_mismatch_o); end
  endtask

  task automatic test_mismatch();
    int n;
    clear_logs();
    start_pass(1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 8, 7, 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    n = 0;
    while (done_o !== 1'b1 && n < 80) begin @(negedge clk); n++; end
    compared++; if (done_o !== 1'b1) begin failed++; $display("FAIL mism_done_timeout: got %b required 1", done_o); end
    compared++; if (oid_q.size() != 1) begin failed++; $display("FAIL mism_oiv_count: got %0d required 1", oid_q.size()); end
    if (oid_q.size() > 0) begin
      compared++; if (oid_q[0] !== ID_WIDTH'(8)) begin failed++; $display("FAIL mism_out_id: got %0d required 8", oid_q[0]); end
    end
    compared++; if (err_mismatch_o !== 1'b1) begin failed++; $display("FAIL mism_sticky: got %b required 1", err_mismatch_o); end
    // Zero-particle pass clears the flag and completes next cycle
    start_pass(0, 1'b0);
    compared++; if (err_mismatch_o !== 1'b0) begin failed++; $display("FAIL mism_cleared: got %b required 0", err_mismatch_o); end
    compared++; if ({busy_o, done_o} !== 2'b01) begin failed++; $display("FAIL zero_pass_status: got %b required 01", {busy_o, done_o}); end
    compared++; if (issued_cnt_o !== '0) begin failed++; $display("FAIL zero_pass_issued: got %0d required 0", issued_cnt_o); end
  endtask

  task automatic test_latency();
    int n;
    clear_logs();
    stub_lat = 5;
    start_pass(1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 3, 3, 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    n = 0;
    while (done_o !== 1'b1 && n < 80) begin @(negedge clk); n++; end
    compared++; if (done_o !== 1'b1) begin failed++; $display("FAIL lat_done_timeout: got %b required 1", done_o); end
    compared++; if (err_latency_o !== 1'b1) begin failed++; $display("FAIL lat_err: got %b required 1", err_latency_o); end
    compared++; if (err_mismatch_o !== 1'b0) begin failed++; $display("FAIL lat_mismatch: got %b required 0", err_mismatch_o); end
    @(negedge clk);
    stub_lat = 6;
  endtask

  task automatic test_rst_midpass();
    int n;
    start_pass(4, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 0, 0, 0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1, 0, 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    compared++; if (busy_o !== 1'b1) begin failed++; $display("FAIL rst_pre_busy: got %b required 1", busy_o); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    compared++; if ({lr_ready_o, sr_ready_o, bf_ready_o} !== 3'b111) begin failed++; $display("FAIL rst_ready: got %b required 111", {lr_ready_o, sr_ready_o, bf_ready_o}); end
    compared++; if ({out_id_valid_o, busy_o, done_o} !== 3'b000) begin failed++; $display("FAIL rst_status: got %b required 000", {out_id_valid_o, busy_o, done_o}); end
    clear_logs();
    start_pass(2, 1'b1);
    for (int i = 10; i < 12; i++) begin
      drive(1'b1, 1'b1, 1'b1, i, i, i);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    n = 0;
    while (done_o !== 1'b1 && n < 80) begin @(negedge clk); n++; end
    compared++; if (done_o !== 1'b1) begin failed++; $display("FAIL rst_fresh_done: got %b required 1", done_o); end
    compared++; if (oid_q.size() != 2) begin failed++; $display("FAIL rst_fresh_count: got %0d required 2", oid_q.size()); end
    for (int k = 0; k < 2 && k < oid_q.size(); k++) begin
      compared++;
      if (oid_q[k] !== ID_WIDTH'(10 + k)) begin failed++; $display("FAIL rst_fresh_out_id%0d: got %0d required %0d", k, oid_q[k], 10 + k); end
    end
    compared++; if ({err_mismatch_o, err_latency_o} !== 2'b00) begin failed++; $display("FAIL rst_fresh_errs: got %b required 00", {err_mismatch_o, err_latency_o}); end
    compared++; if (issued_cnt_o !== CNT_WIDTH'(2)) begin failed++; $display("FAIL rst_fresh_issued: got %0d required 2", issued_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bf_off();
    test_skew();
    test_mismatch();
    test_latency();
    test_rst_midpass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
